// File: rtl/ksa_pkg.sv
// Shared widths and FSM encoding for the sequential 32-bit Kogge-Stone adder.
package ksa_pkg;

    localparam int WORD_W  = 16;
    localparam int DWORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/ksa16.sv
// 16-bit Kogge-Stone adder core, carry-in fixed at 0, purely combinational.
module ksa16
    import ksa_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    output logic [WORD_W-1:0] o_sum,
    output logic              o_cout
);

    logic [WORD_W-1:0] w_g0, w_p0;
    logic [WORD_W-1:0] w_g1, w_p1;
    logic [WORD_W-1:0] w_g2, w_p2;
    logic [WORD_W-1:0] w_g3, w_p3;
    logic [WORD_W-1:0] w_g4;

    assign w_g0 = i_a & i_b;
    assign w_p0 = i_a ^ i_b;

    // Prefix levels at span 1, 2, 4, 8; shifted-in zeros terminate the low bits.
    assign w_g1 = w_g0 | (w_p0 & (w_g0 << 1));
    assign w_p1 = w_p0 & (w_p0 << 1);
    assign w_g2 = w_g1 | (w_p1 & (w_g1 << 2));
    assign w_p2 = w_p1 & (w_p1 << 2);
    assign w_g3 = w_g2 | (w_p2 & (w_g2 << 4));
    assign w_p3 = w_p2 & (w_p2 << 4);
    assign w_g4 = w_g3 | (w_p3 & (w_g3 << 8));

    assign o_sum[0] = w_p0[0];

    genvar gi;
    generate
        for (gi = 1; gi < WORD_W; gi++) begin : g_sum
            assign o_sum[gi] = w_p0[gi] ^ w_g4[gi-1];
        end
    endgenerate

    assign o_cout = w_g4[WORD_W-1];

endmodule

// File: rtl/ksa32_seq.sv
// 32-bit adder built from three passes of one KSA16 core: low half, high half,
// then adding the low carry into the high half. Optional accumulate operand.
module ksa32_seq
    import ksa_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWORD_W-1:0] in_a,
    input  logic [DWORD_W-1:0] in_b,
    input  logic               in_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DWORD_W-1:0] out_sum,
    output logic               out_cout
);

    state_t             r_state;
    state_t             w_state_next;
    logic [DWORD_W-1:0] r_a;
    logic [DWORD_W-1:0] r_b;
    logic [DWORD_W-1:0] r_acc;
    logic [WORD_W-1:0]  r_sum_lo;
    logic               r_c0;
    logic [WORD_W-1:0]  r_t;
    logic               r_c1;
    logic [DWORD_W-1:0] r_sum;
    logic               r_cout;

    logic [WORD_W-1:0]  w_core_a;
    logic [WORD_W-1:0]  w_core_b;
    logic [WORD_W-1:0]  w_core_sum;
    logic               w_core_cout;

    ksa16 u_core (
        .i_a    (w_core_a),
        .i_b    (w_core_b),
        .o_sum  (w_core_sum),
        .o_cout (w_core_cout)
    );

    always_comb begin
        w_core_a = '0;
        w_core_b = '0;
        case (r_state)
            ST_LO: begin
                w_core_a = r_a[WORD_W-1:0];
                w_core_b = r_b[WORD_W-1:0];
            end
            ST_HI: begin
                w_core_a = r_a[DWORD_W-1:WORD_W];
                w_core_b = r_b[DWORD_W-1:WORD_W];
            end
            ST_FIX: begin
                w_core_a = r_t;
                w_core_b = {{(WORD_W-1){1'b0}}, r_c0};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_LO;
            end
            ST_LO:   w_state_next = ST_HI;
            ST_HI:   w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_sum_lo <= '0;
            r_c0     <= 1'b0;
            r_t      <= '0;
            r_c1     <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a <= in_a;
                        r_b <= in_acc ? r_acc : in_b;
                    end
                end
                ST_LO: begin
                    r_sum_lo <= w_core_sum;
                    r_c0     <= w_core_cout;
                end
                ST_HI: begin
                    r_t  <= w_core_sum;
                    r_c1 <= w_core_cout;
                end
                ST_FIX: begin
                    // c1 set implies t <= 0xFFFE, so at most one carry source fires.
                    r_sum  <= {w_core_sum, r_sum_lo};
                    r_cout <= r_c1 | w_core_cout;
                    r_acc  <= {w_core_sum, r_sum_lo};
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;

endmodule

// File: tb/tb_ksa32_seq.sv
// Randomized and directed bench for ksa32_seq against a cycle-level behavioural model.
module tb_ksa32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_acc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_cout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: transaction pending, cycles since accept, expected result.
    logic        m_pending = 1'b0;
    logic        m_valid = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_sum = '0;
    logic        m_cout = 1'b0;
    logic [31:0] m_acc = '0;

    logic [31:0] last_sum = '0;
    logic        last_cout = 1'b0;

    always #5 clk = ~clk;

    ksa32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_valid   <= 1'b0;
            m_cnt     <= 0;
            m_acc     <= '0;
        end else if (m_pending) begin
            if (m_valid && out_ready) begin
                m_pending <= 1'b0;
                m_valid   <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 >= 3) m_valid <= 1'b1;
            end
        end else if (in_valid) begin
            logic [31:0] opb;
            logic [32:0] full;
            opb  = in_acc ? m_acc : in_b;
            full = {1'b0, in_a} + {1'b0, opb};
            m_sum     <= full[31:0];
            m_cout    <= full[32];
            m_acc     <= full[31:0];
            m_pending <= 1'b1;
            m_cnt     <= 0;
            m_valid   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        checks = checks + 2;
        if (in_ready !== !m_pending) begin
            errors = errors + 1;
            $display("FAIL in_ready t=%0t actual=%b required=%b", $time, in_ready, !m_pending);
        end
        if (out_valid !== m_valid) begin
            errors = errors + 1;
            $display("FAIL out_valid t=%0t actual=%b required=%b", $time, out_valid, m_valid);
        end
        if (m_valid) begin
            checks = checks + 1;
            if (out_sum !== m_sum || out_cout !== m_cout) begin
                errors = errors + 1;
                $display("FAIL result t=%0t actual=%h/%b required=%h/%b",
                         $time, out_sum, out_cout, m_sum, m_cout);
            end
        end
        if (out_valid) begin
            last_sum  = out_sum;
            last_cout = out_cout;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic acc,
                        input int hold, input logic poke, input logic lit,
                        input logic [31:0] exp_sum, input logic exp_cout);
        int n;
        @(negedge clk);
        #1;
        in_a = a; in_b = b; in_acc = acc; in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_pending && n < 20);
        in_valid = 1'b0;
        if (!m_pending) begin
            errors++;
            $display("FAIL accept_timeout a=%h actual=no accept required=accept", a);
            return;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL valid_timeout a=%h actual=0 required=1", a);
        end
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_a = $urandom;
                in_acc = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("txn a=%h b=%h acc=%b hold=%0d sum=%h cout=%b", a, b, acc, hold, last_sum, last_cout);
        if (lit) begin
            checks++;
            if (last_sum !== exp_sum || last_cout !== exp_cout) begin
                errors++;
                $display("FAIL literal a=%h actual=%h/%b required=%h/%b",
                         a, last_sum, last_cout, exp_sum, exp_cout);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2;
        checks = checks + 4;
        if (out_sum !== 32'h0 || out_cout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state actual=%h/%b/%b/%b required=0/0/0/1",
                     out_sum, out_cout, out_valid, in_ready);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        send(32'h0000FFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b1, 32'h00010000, 1'b0);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b1, 32'h00000000, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 0, 1'b0, 1'b1, 32'h00000000, 1'b1);
        send(32'h12345678, 32'h11111111, 1'b0, 6, 1'b1, 1'b1, 32'h23456789, 1'b0);

        pulse_reset();
        send(32'h00000005, 32'hDEADBEEF, 1'b1, 0, 1'b0, 1'b1, 32'h00000005, 1'b0);
        send(32'hFFFFFFFE, 32'h0BADF00D, 1'b1, 0, 1'b0, 1'b1, 32'h00000003, 1'b1);

        // Reset while the FSM sits in HI.
        @(negedge clk); #1;
        in_a = 32'h11112222; in_b = 32'h33334444; in_acc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks = checks + 2;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset actual=%b/%b required=0/1", out_valid, in_ready);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        send(32'h00000007, 32'h12345678, 1'b1, 0, 1'b0, 1'b1, 32'h00000007, 1'b0);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h00000001 : $urandom;
            send(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
